fifo_out_reader: RTL

FIFO_OUT_READER -- requirements
Module: fifo_out_reader

---
 rtl/fifo_out_reader.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_out_reader.sv
// Read side of an 8-entry register FIFO: pops entries from externally held
// storage, tracks occupancy and reports ack/error one cycle after each pop.
module fifo_out_reader #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] d_in0,
  input  logic [DW-1:0] d_in1,
  input  logic [DW-1:0] d_in2,
  input  logic [DW-1:0] d_in3,
  input  logic [DW-1:0] d_in4,
  input  logic [DW-1:0] d_in5,
  input  logic [DW-1:0] d_in6,
  input  logic [DW-1:0] d_in7,
  input  logic          rd_en,
  output logic [DW-1:0] d_out,
  output logic          rd_ack,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic [3:0]    data_count,
  output logic [2:0]    rd_ptr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    RD_ERR = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_dout;
  logic [3:0]    r_count;
  logic [2:0]    r_ptr;

  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_rdata;

  assign empty  = (r_count == 4'd0);
  assign full   = (r_count == 4'd8);
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;

  always_comb begin
    w_rdata = d_in0;
    unique case (r_ptr)
      3'd0: w_rdata = d_in0;
      3'd1: w_rdata = d_in1;
      3'd2: w_rdata = d_in2;
      3'd3: w_rdata = d_in3;
      3'd4: w_rdata = d_in4;
      3'd5: w_rdata = d_in5;
      3'd6: w_rdata = d_in6;
      3'd7: w_rdata = d_in7;
      default: w_rdata = d_in0;
    endcase
  end

  // Count moves only when exactly one side is accepted; accept
  // gating on full/empty keeps it within 0..8.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + 4'd1;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      r_dout  <= '0;
    end else begin
      if (!rd_en) begin
        r_state <= IDLE;
      end else if (empty) begin
        r_state <= RD_ERR;
      end else begin
        r_state <= READ;
        r_dout  <= w_rdata;
        r_ptr   <= r_ptr + 3'd1;
      end
    end
  end

  assign d_out      = r_dout;
  assign rd_ack     = (r_state == READ);
  assign rd_err     = (r_state == RD_ERR);
  assign data_count = r_count;
  assign rd_ptr     = r_ptr;

endmodule
